// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues DIV/DIVU operands to the signed/unsigned divider IPs
// over AXI-stream, captures the 64-bit result for the EXE stage, and drains
// divides that were flushed while in flight.
module div_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_signed,
    input  logic [31:0] op_dividend,
    input  logic [31:0] op_divisor,
    input  logic        flush,
    input  logic        stage_advance,
    output logic        done,
    output logic        busy,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic [31:0] div_dividend_tdata,
    output logic [31:0] div_divisor_tdata,
    output logic        s_dividend_tvalid,
    output logic        s_divisor_tvalid,
    input  logic        s_dividend_tready,
    input  logic        s_divisor_tready,
    input  logic        s_dout_tvalid,
    input  logic [63:0] s_dout_tdata,
    output logic        u_dividend_tvalid,
    output logic        u_divisor_tvalid,
    input  logic        u_dividend_tready,
    input  logic        u_divisor_tready,
    input  logic        u_dout_tvalid,
    input  logic [63:0] u_dout_tdata
);

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          sel, sel_nxt;
    logic          killed, killed_nxt;
    logic          pend_dd, pend_dd_nxt;
    logic          pend_dv, pend_dv_nxt;
    logic [DW-1:0] dd_q, dd_nxt;
    logic [DW-1:0] dv_q, dv_nxt;
    logic [RW-1:0] res_q, res_nxt;

    // Handshake and result inputs of whichever IP the current divide uses
    logic          dd_ready_c;
    logic          dv_ready_c;
    logic          dout_valid_c;
    logic [RW-1:0] dout_data_c;

    assign dd_ready_c   = sel ? s_dividend_tready : u_dividend_tready;
    assign dv_ready_c   = sel ? s_divisor_tready  : u_divisor_tready;
    assign dout_valid_c = sel ? s_dout_tvalid     : u_dout_tvalid;
    assign dout_data_c  = sel ? s_dout_tdata      : u_dout_tdata;

    // Operands and result come straight from their holding registers
    assign div_dividend_tdata = dd_q;
    assign div_divisor_tdata  = dv_q;
    assign quotient           = res_q[RW-1:DW];
    assign remainder          = res_q[DW-1:0];

    // Next-state and datapath decisions
    always_comb begin
        state_nxt   = state;
        sel_nxt     = sel;
        killed_nxt  = killed;
        pend_dd_nxt = pend_dd;
        pend_dv_nxt = pend_dv;
        dd_nxt      = dd_q;
        dv_nxt      = dv_q;
        res_nxt     = res_q;

        unique case (state)
            IDLE: begin
                if (op_valid && !flush) begin
                    dd_nxt      = op_dividend;
                    dv_nxt      = op_divisor;
                    sel_nxt     = op_signed;
                    pend_dd_nxt = 1'b1;
                    pend_dv_nxt = 1'b1;
                    killed_nxt  = 1'b0;
                    state_nxt   = SEND;
                end
            end
            SEND: begin
                // Valids are never withdrawn: a flush only marks the divide dead
                if (flush) begin
                    killed_nxt = 1'b1;
                end
                if (pend_dd && dd_ready_c) begin
                    pend_dd_nxt = 1'b0;
                end
                if (pend_dv && dv_ready_c) begin
                    pend_dv_nxt = 1'b0;
                end
                if (!pend_dd_nxt && !pend_dv_nxt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    killed_nxt = 1'b1;
                end
                if (dout_valid_c) begin
                    // A flush arriving with the result still kills it
                    if (killed || flush) begin
                        killed_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end else begin
                        res_nxt   = dout_data_c;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (flush || stage_advance) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, internal registers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            sel               <= 1'b0;
            killed            <= 1'b0;
            pend_dd           <= 1'b0;
            pend_dv           <= 1'b0;
            dd_q              <= '0;
            dv_q              <= '0;
            res_q             <= '0;
            done              <= 1'b0;
            busy              <= 1'b0;
            s_dividend_tvalid <= 1'b0;
            s_divisor_tvalid  <= 1'b0;
            u_dividend_tvalid <= 1'b0;
            u_divisor_tvalid  <= 1'b0;
        end else begin
            state             <= state_nxt;
            sel               <= sel_nxt;
            killed            <= killed_nxt;
            pend_dd           <= pend_dd_nxt;
            pend_dv           <= pend_dv_nxt;
            dd_q              <= dd_nxt;
            dv_q              <= dv_nxt;
            res_q             <= res_nxt;
            done              <= (state_nxt == DONE);
            busy              <= (state_nxt != IDLE);
            s_dividend_tvalid <= sel_nxt  & pend_dd_nxt;
            s_divisor_tvalid  <= sel_nxt  & pend_dv_nxt;
            u_dividend_tvalid <= !sel_nxt & pend_dd_nxt;
            u_divisor_tvalid  <= !sel_nxt & pend_dv_nxt;
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed vectors plus hand-written corner sequences for
// div_issue_ctrl, with a small behavioural model of the two divider IPs.
module tb_div_issue_ctrl;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_signed;
    logic [31:0] op_dividend;
    logic [31:0] op_divisor;
    logic        flush;
    logic        stage_advance;
    logic        done;
    logic        busy;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic [31:0] div_dividend_tdata;
    logic [31:0] div_divisor_tdata;
    logic        s_dividend_tvalid, s_divisor_tvalid;
    logic        s_dividend_tready, s_divisor_tready;
    logic        s_dout_tvalid;
    logic [63:0] s_dout_tdata;
    logic        u_dividend_tvalid, u_divisor_tvalid;
    logic        u_dividend_tready, u_divisor_tready;
    logic        u_dout_tvalid;
    logic [63:0] u_dout_tdata;

    div_issue_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .op_valid           (op_valid),
        .op_signed          (op_signed),
        .op_dividend        (op_dividend),
        .op_divisor         (op_divisor),
        .flush              (flush),
        .stage_advance      (stage_advance),
        .done               (done),
        .busy               (busy),
        .quotient           (quotient),
        .remainder          (remainder),
        .div_dividend_tdata (div_dividend_tdata),
        .div_divisor_tdata  (div_divisor_tdata),
        .s_dividend_tvalid  (s_dividend_tvalid),
        .s_divisor_tvalid   (s_divisor_tvalid),
        .s_dividend_tready  (s_dividend_tready),
        .s_divisor_tready   (s_divisor_tready),
        .s_dout_tvalid      (s_dout_tvalid),
        .s_dout_tdata       (s_dout_tdata),
        .u_dividend_tvalid  (u_dividend_tvalid),
        .u_divisor_tvalid   (u_divisor_tvalid),
        .u_dividend_tready  (u_dividend_tready),
        .u_divisor_tready   (u_divisor_tready),
        .u_dout_tvalid      (u_dout_tvalid),
        .u_dout_tdata       (u_dout_tdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- divider IP model ----------------
    localparam logic [63:0] GARBAGE = 64'hDEAD_BEEF_0BAD_F00D;

    int          dd_wait, dv_wait, lat;
    int          dd_cnt, dv_cnt, ip_cnt;
    logic        got_dd, got_dv, cap_s, ip_sel, stray_s, stray_u;
    logic [31:0] cap_a, cap_b;
    logic [63:0] ip_data;
    logic        hs_dd, hs_dv, nd, nv, s_n;
    logic [31:0] a_n, b_n;
    logic        dd_rdy, dv_rdy;

    function automatic logic [63:0] ip_fn(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0]        q, r;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    assign dd_rdy = (dd_cnt >= dd_wait);
    assign dv_rdy = (dv_cnt >= dv_wait);
    assign s_dividend_tready = dd_rdy;
    assign u_dividend_tready = dd_rdy;
    assign s_divisor_tready  = dv_rdy;
    assign u_divisor_tready  = dv_rdy;
    // Real result on the used IP; the other IP emits a garbage pulse one cycle earlier
    assign s_dout_tvalid = (ip_sel && ip_cnt == 1) || (!ip_sel && ip_cnt == 2) || stray_s;
    assign u_dout_tvalid = (!ip_sel && ip_cnt == 1) || (ip_sel && ip_cnt == 2) || stray_u;
    assign s_dout_tdata  = (ip_sel && ip_cnt == 1) ? ip_data : GARBAGE;
    assign u_dout_tdata  = (!ip_sel && ip_cnt == 1) ? ip_data : GARBAGE;

    // Accept operands when valid&ready, then return the quotient/remainder lat cycles later
    always @(posedge clk) begin
        if (reset) begin
            dd_cnt <= 0; dv_cnt <= 0; ip_cnt <= 0;
            got_dd <= 1'b0; got_dv <= 1'b0; ip_sel <= 1'b0;
        end else begin
            hs_dd = (s_dividend_tvalid || u_dividend_tvalid) && dd_rdy;
            hs_dv = (s_divisor_tvalid  || u_divisor_tvalid)  && dv_rdy;
            a_n = hs_dd ? div_dividend_tdata : cap_a;
            s_n = hs_dd ? s_dividend_tvalid  : cap_s;
            b_n = hs_dv ? div_divisor_tdata  : cap_b;
            if (hs_dd) dd_cnt <= 0;
            else if (s_dividend_tvalid || u_dividend_tvalid) dd_cnt <= dd_cnt + 1;
            if (hs_dv) dv_cnt <= 0;
            else if (s_divisor_tvalid || u_divisor_tvalid) dv_cnt <= dv_cnt + 1;
            nd = got_dd || hs_dd;
            nv = got_dv || hs_dv;
            if (nd && nv) begin
                got_dd <= 1'b0; got_dv <= 1'b0;
                ip_cnt <= lat;
                ip_data <= ip_fn(s_n, a_n, b_n);
                ip_sel <= s_n;
            end else begin
                got_dd <= nd; got_dv <= nv;
                if (ip_cnt != 0) ip_cnt <= ip_cnt - 1;
            end
            cap_a <= a_n; cap_b <= b_n; cap_s <= s_n;
        end
    end

    // ---------------- checking ----------------
    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a, b;
        int          ddw, dvw, lat;
        logic [31:0] eq, er;
        int          elat;
    } vec_t;

    vec_t vecs[7];

    // One complete divide: issue, wait for done, hold, then advance
    task automatic run_vec(input vec_t v, input int idx);
        int   cyc, ddc, dvc, wrong;
        logic tdata_ok, hold_ok;
        dd_wait = v.ddw; dv_wait = v.dvw; lat = v.lat;
        op_valid = 1'b1; op_signed = v.s; op_dividend = v.a; op_divisor = v.b;
        cyc = 0; ddc = 0; dvc = 0; wrong = 0; tdata_ok = 1'b1;
        do begin
            tick();
            cyc++;
            if (v.s ? s_dividend_tvalid : u_dividend_tvalid) ddc++;
            if (v.s ? s_divisor_tvalid  : u_divisor_tvalid)  dvc++;
            if (v.s ? (u_dividend_tvalid || u_divisor_tvalid) : (s_dividend_tvalid || s_divisor_tvalid)) wrong++;
            if ((s_dividend_tvalid || u_dividend_tvalid) && div_dividend_tdata !== v.a) tdata_ok = 1'b0;
            if ((s_divisor_tvalid  || u_divisor_tvalid)  && div_divisor_tdata  !== v.b) tdata_ok = 1'b0;
        end while (!done && cyc < 200);
        chk($sformatf("v%0d_latency", idx), 64'(cyc), 64'(v.elat));
        chk($sformatf("v%0d_quotient", idx), 64'(quotient), 64'(v.eq));
        chk($sformatf("v%0d_remainder", idx), 64'(remainder), 64'(v.er));
        chk($sformatf("v%0d_dd_valid_cycles", idx), 64'(ddc), 64'(v.ddw + 1));
        chk($sformatf("v%0d_dv_valid_cycles", idx), 64'(dvc), 64'(v.dvw + 1));
        chk($sformatf("v%0d_other_ip_valid", idx), 64'(wrong), 64'd0);
        chk($sformatf("v%0d_tdata_stable", idx), 64'(tdata_ok), 64'd1);
        hold_ok = 1'b1;
        repeat (5) begin
            tick();
            if (!done || !busy || quotient !== v.eq || remainder !== v.er) hold_ok = 1'b0;
        end
        chk($sformatf("v%0d_hold", idx), 64'(hold_ok), 64'd1);
        stage_advance = 1'b1; op_valid = 1'b0;
        tick();
        stage_advance = 1'b0;
        chk($sformatf("v%0d_done_after_adv", idx), 64'({done, busy}), 64'd0);
    endtask

    initial begin
        reset = 1'b1; op_valid = 1'b0; op_signed = 1'b0; op_dividend = '0; op_divisor = '0;
        flush = 1'b0; stage_advance = 1'b0; stray_s = 1'b0; stray_u = 1'b0;
        dd_wait = 0; dv_wait = 0; lat = 1;
        cap_a = '0; cap_b = '0; cap_s = 1'b0; ip_data = '0;
        repeat (3) tick();
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tvalids", 64'({s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}), 64'd0);
        chk("rst_quotient", 64'(quotient), 64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        reset = 1'b0;
        tick();

        //        s     a              b              ddw dvw lat  eq             er             elat
        vecs[0] = '{1'b1, 32'd7,        32'hFFFF_FFFE, 0, 0, 10, 32'hFFFF_FFFD, 32'h0000_0001, 12};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h10,       0, 0, 3,  32'h0FFF_FFFF, 32'h0000_000F, 5};
        vecs[2] = '{1'b0, 32'd100,      32'd7,         0, 2, 4,  32'd14,        32'd2,         8};
        vecs[3] = '{1'b1, 32'hFFFF_FF9C, 32'd7,        3, 1, 1,  32'hFFFF_FFF2, 32'hFFFF_FFFE, 6};
        vecs[4] = '{1'b1, 32'h1234_5678, 32'd0,        0, 0, 2,  32'hFFFF_FFFF, 32'h1234_5678, 4};
        vecs[5] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'd0,         32'h8000_0000, 3};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'd2,        1, 1, 5,  32'hC000_0000, 32'd0,         8};
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Flush in WAIT: killed divide drains, waiting op only starts from IDLE
        begin
            logic done_seen, busy_ok, early;
            dd_wait = 0; dv_wait = 0; lat = 6;
            op_valid = 1'b1; op_signed = 1'b1; op_dividend = 32'd50; op_divisor = 32'd7;
            done_seen = 1'b0; busy_ok = 1'b1; early = 1'b0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (c < 12 && done) done_seen = 1'b1;
                if (c <= 7 && !busy) busy_ok = 1'b0;
                if (c == 8 && busy) busy_ok = 1'b0;
                if (c <= 8 && (u_dividend_tvalid || u_divisor_tvalid)) early = 1'b1;
                if (c == 9) chk("flush_next_issue", 64'({u_dividend_tvalid, u_divisor_tvalid}), 64'd3);
                if (c == 3) begin flush = 1'b1; op_valid = 1'b0; end
                if (c == 4) begin
                    flush = 1'b0; lat = 2;
                    op_valid = 1'b1; op_signed = 1'b0; op_dividend = 32'd9; op_divisor = 32'd4;
                end
            end
            chk("flush_no_done", 64'(done_seen), 64'd0);
            chk("flush_busy_drain", 64'(busy_ok), 64'd1);
            chk("flush_no_early_accept", 64'(early), 64'd0);
            chk("flush_next_done", 64'(done), 64'd1);
            chk("flush_next_result", {quotient, remainder}, {32'd2, 32'd1});
            flush = 1'b1; op_valid = 1'b0;
            tick();
            flush = 1'b0;
            chk("flush_in_done", 64'({done, busy}), 64'd0);
        end

        // Reset while in SEND, then a stale result pulse while idle
        begin
            logic idle_ok;
            dd_wait = 5; dv_wait = 5; lat = 3;
            op_valid = 1'b1; op_signed = 1'b1; op_dividend = 32'd1; op_divisor = 32'd1;
            tick();
            chk("rst_mid_send_valid", 64'({s_dividend_tvalid, s_divisor_tvalid}), 64'd3);
            tick();
            reset = 1'b1; op_valid = 1'b0;
            tick();
            reset = 1'b0;
            chk("rst_mid_tvalids", 64'({s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid}), 64'd0);
            chk("rst_mid_busy_done", 64'({busy, done}), 64'd0);
            dd_wait = 0; dv_wait = 0;
            stray_s = 1'b1; stray_u = 1'b1;
            tick();
            stray_s = 1'b0; stray_u = 1'b0;
            idle_ok = 1'b1;
            repeat (4) begin
                tick();
                if (done || busy || quotient !== 32'd0 || remainder !== 32'd0) idle_ok = 1'b0;
            end
            chk("stale_dout_ignored", 64'(idle_ok), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
